// File: rtl/step_counter_pkg.sv
// Shared encodings for the step counter responder: FSM states and run direction.
package step_counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic DIR_BWD = 1'b0;
   localparam logic DIR_FWD = 1'b1;

endpackage

// File: rtl/step_tick_divider.sv
// Step tick divider: emits a tick once every PRESCALE clk cycles while run is high.
// Only instantiated when STEP_COUNTER_PRESCALE_EN is defined.
module step_tick_divider
   import step_counter_pkg::*;
#(
   parameter int unsigned PRESCALE = 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic run,
   output logic tick
);

   // PRESCALE = 1 still needs a one-bit register; it just never leaves zero.
   localparam int unsigned DIV_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PRESCALE - 1);

   logic [DIV_W-1:0] div_q;

   assign tick = (div_q == DIV_LAST);

   // Divider: cleared on command accept, advances only in RUN, wraps on tick.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q <= '0;
      end else if (clear) begin
         div_q <= '0;
      end else if (run) begin
         if (tick) begin
            div_q <= '0;
         end else begin
            div_q <= div_q + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/step_counter_responder.sv
// Step counter responder: accepts a run command (up to TOP or down to 0), steps count toward
// the terminal value and pulses finish for one cycle on arrival. abort cancels a run.
// Optional prescaled stepping is compiled in with STEP_COUNTER_PRESCALE_EN.
module step_counter_responder
   import step_counter_pkg::*;
#(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             cmd_valid,
   input  logic             cmd_forward,
   output logic             cmd_ready,
   input  logic             abort,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             finish
);

   localparam logic [WIDTH-1:0] TOP = {WIDTH{1'b1}};

   if (PRESCALE < 1) begin : gen_bad_prescale
      $error("PRESCALE must be at least 1");
   end

   state_e           state_q;
   logic [WIDTH-1:0] count_q;
   logic             dir_q;
   logic             accept;
   logic             tick;
   logic [WIDTH-1:0] terminal;

   assign accept   = cmd_valid && (state_q == ST_IDLE);
   assign terminal = (dir_q == DIR_FWD) ? TOP : '0;

`ifdef STEP_COUNTER_PRESCALE_EN
   step_tick_divider #(
      .PRESCALE (PRESCALE)
   ) u_divider (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (accept),
      .run     (state_q == ST_RUN),
      .tick    (tick)
   );
`else
   assign tick = 1'b1;
`endif

   // Run FSM; the terminal check precedes the step, so count never wraps.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         dir_q   <= DIR_FWD;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  dir_q   <= cmd_forward;
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (abort) begin
                  state_q <= ST_IDLE;
               end else if (count_q == terminal) begin
                  state_q <= ST_DONE;
               end else if (tick) begin
                  if (dir_q == DIR_BWD) begin
                     count_q <= count_q - WIDTH'(1);
                  end else begin
                     count_q <= count_q + WIDTH'(1);
                  end
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Outputs decode straight from the registered state.
   always_comb begin
      cmd_ready = (state_q == ST_IDLE);
      busy      = (state_q == ST_RUN);
      finish    = (state_q == ST_DONE);
      count     = count_q;
   end

endmodule

// File: tb/tb_step_counter_responder.sv
// Directed bench for step_counter_responder. Expected values are hand-derived; step spacing
// P is 3 when STEP_COUNTER_PRESCALE_EN is defined, otherwise 1.
module tb_step_counter_responder;

`ifdef STEP_COUNTER_PRESCALE_EN
   localparam int P = 3;
`else
   localparam int P = 1;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_forward = 1'b0;
   logic       abort = 1'b0;
   logic       cmd_ready;
   logic [3:0] count;
   logic       busy;
   logic       finish;

   int n_tests = 0;
   int n_fail  = 0;

   step_counter_responder #(
      .WIDTH    (4),
      .PRESCALE (P)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .cmd_valid   (cmd_valid),
      .cmd_forward (cmd_forward),
      .cmd_ready   (cmd_ready),
      .abort       (abort),
      .count       (count),
      .busy        (busy),
      .finish      (finish)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one clk edge and settle away from it.
   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   // Present a command for exactly one accepting edge.
   task automatic issue(input logic fwd);
      cmd_valid   = 1'b1;
      cmd_forward = fwd;
      edge1();
      cmd_valid   = 1'b0;
      check_eq("accept_busy", busy, 1);
      check_eq("accept_ready", cmd_ready, 0);
   endtask

   // Expect n count steps, P edges apart, from start in the given direction.
   task automatic expect_steps(input int start, input logic fwd, input int n);
      for (int k = 1; k <= n; k++) begin
         repeat (P) edge1();
         check_eq("step_count", count, fwd ? start + k : start - k);
         check_eq("step_no_finish", finish, 0);
      end
   endtask

   // Terminal reached: one more edge to DONE, then IDLE.
   task automatic expect_finish(input int final_count);
      edge1();
      check_eq("finish_pulse", finish, 1);
      check_eq("finish_busy", busy, 0);
      check_eq("finish_count", count, final_count);
      edge1();
      check_eq("finish_single", finish, 0);
      check_eq("finish_ready", cmd_ready, 1);
   endtask

   initial begin
      // Reset state
      #12;
      check_eq("rst_count", count, 0);
      check_eq("rst_ready", cmd_ready, 1);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_finish", finish, 0);
      @(negedge clk);
      reset_n = 1'b1;
      edge1();

      // Forward 0 -> 15
      issue(1'b1);
      check_eq("fwd_start", count, 0);
      expect_steps(0, 1'b1, 15);
      expect_finish(15);

      // Forward while already at TOP: one RUN cycle, then DONE
      issue(1'b1);
      check_eq("top_hold", count, 15);
      expect_finish(15);

      // Backward 15 -> 0, with a stray cmd_valid held mid-run that must be ignored
      issue(1'b0);
      for (int k = 1; k <= 15; k++) begin
         if (k == 5) begin
            cmd_valid   = 1'b1;
            cmd_forward = 1'b1;
         end
         if (k == 9) cmd_valid = 1'b0;
         repeat (P) edge1();
         check_eq("bwd_count", count, 15 - k);
         check_eq("bwd_busy", busy, 1);
      end
      expect_finish(0);
      check_eq("bwd_idle_busy", busy, 0);

      // Abort at count 7 of a forward run
      issue(1'b1);
      expect_steps(0, 1'b1, 7);
      abort = 1'b1;
      edge1();
      check_eq("abort_count", count, 7);
      check_eq("abort_finish", finish, 0);
      check_eq("abort_ready", cmd_ready, 1);
      // abort still high in IDLE: command is accepted anyway
      issue(1'b0);
      abort = 1'b0;
      expect_steps(7, 1'b0, 7);
      expect_finish(0);

      // Asynchronous reset mid-run at count 9
      issue(1'b1);
      expect_steps(0, 1'b1, 9);
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("arst_count", count, 0);
      check_eq("arst_busy", busy, 0);
      check_eq("arst_finish", finish, 0);
      check_eq("arst_ready", cmd_ready, 1);
      @(negedge clk);
      reset_n = 1'b1;
      edge1();
      check_eq("post_rst_idle", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
